// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcode constants and sequencer state encoding for the
//               alu_seq phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [7:0] OP_PUSH = 8'h55;
    localparam logic [7:0] OP_MOV  = 8'h89;
    localparam logic [7:0] OP_MOVI = 8'hb8;
    localparam logic [7:0] OP_POP  = 8'h5d;
    localparam logic [7:0] OP_RET  = 8'hc3;
    localparam logic [7:0] OP_CALL = 8'he8;

    // Phase states share their encoding with the reported phase number.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        PH3  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_fn.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_fn
// Description : Combinational per-phase result function. Given the latched
//               opcode, the current phase and the operands, produces the
//               phase result, a last-phase flag and an opcode-legal flag.
//               Build option: ALU_SEQ_CALL_REL_EN selects a relative call
//               target in call phase 3 (otherwise phase 3 yields zero).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_fn
    import alu_seq_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STACK_STEP = 1
) (
    input  logic [7:0]        opcode,
    input  logic [1:0]        phase_num,
    input  logic [23:0]       operand,
    input  logic [DATA_W-1:0] reg_in,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              last,
    output logic              legal
);

    localparam logic [DATA_W-1:0] C_STEP = DATA_W'(STACK_STEP);

    logic [DATA_W-1:0] w_plus;
    logic [DATA_W-1:0] w_minus;
    logic [DATA_W-1:0] w_call3;
    logic [DATA_W-1:0] w_movi;

    // Arithmetic wraps naturally at DATA_W bits.
    assign w_plus  = reg_in + C_STEP;
    assign w_minus = reg_in - C_STEP;
    // Immediate bytes are stored little-endian in the operand field.
    assign w_movi  = DATA_W'({operand[7:0], operand[15:8], operand[23:16]});

`ifdef ALU_SEQ_CALL_REL_EN
    assign w_call3 = reg_in + imm;
`else
    logic w_unused_imm;
    assign w_unused_imm = ^imm;
    assign w_call3      = '0;
`endif

    // Select the result for the current phase of the latched opcode.
    always_comb begin
        result = '0;
        last   = 1'b0;
        legal  = 1'b1;
        case (opcode)
            OP_PUSH: begin
                result = (phase_num == 2'd1) ? w_plus : reg_in;
                last   = (phase_num == 2'd2);
            end
            OP_MOV: begin
                result = reg_in;
                last   = 1'b1;
            end
            OP_MOVI: begin
                result = (phase_num == 2'd1) ? w_movi : DATA_W'(3);
                last   = (phase_num == 2'd2);
            end
            OP_POP: begin
                result = (phase_num == 2'd1) ? reg_in : w_minus;
                last   = (phase_num == 2'd2);
            end
            OP_RET: begin
                result = w_minus;
                last   = (phase_num == 2'd2);
            end
            OP_CALL: begin
                case (phase_num)
                    2'd1:    result = w_plus;
                    2'd2:    result = reg_in;
                    default: result = w_call3;
                endcase
                last = (phase_num == 2'd3);
            end
            default: begin
                legal = 1'b0;
                last  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-phase instruction sequencer. Accepts an instruction in
//               IDLE, then emits one registered result per unstalled phase,
//               flagging the final phase with done. Unsupported opcodes
//               produce an illegal+done pulse and no result.
//               Build option: ALU_SEQ_CALL_REL_EN (see alu_seq_fn).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STACK_STEP = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       ope,
    input  logic [DATA_W-1:0] immidiate_data,
    input  logic [DATA_W-1:0] registor_in,
    input  logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] alu_result_bus,
    output logic              result_valid,
    output logic [1:0]        phase,
    output logic              done,
    output logic              illegal
);

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_opcode;
    logic [23:0]       r_operand;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_result;
    logic [1:0]        r_phase;
    logic              r_valid;
    logic              r_done;
    logic              r_illegal;

    logic [DATA_W-1:0] w_result_next;
    logic [1:0]        w_phase_next;
    logic              w_valid_next;
    logic              w_done_next;
    logic              w_illegal_next;
    logic              w_latch;

    logic [1:0]        w_fn_phase;
    logic [DATA_W-1:0] w_fn_result;
    logic              w_fn_last;
    logic              w_fn_legal;

    assign w_fn_phase = r_state;

    alu_seq_fn #(
        .DATA_W     (DATA_W),
        .STACK_STEP (STACK_STEP)
    ) u_fn (
        .opcode    (r_opcode),
        .phase_num (w_fn_phase),
        .operand   (r_operand),
        .reg_in    (registor_in),
        .imm       (r_imm),
        .result    (w_fn_result),
        .last      (w_fn_last),
        .legal     (w_fn_legal)
    );

    // Next state and next registered outputs; pulses default low, data holds.
    always_comb begin
        w_state_next   = r_state;
        w_result_next  = r_result;
        w_phase_next   = r_phase;
        w_valid_next   = 1'b0;
        w_done_next    = 1'b0;
        w_illegal_next = 1'b0;
        w_latch        = 1'b0;
        if (r_state == IDLE) begin
            if (start) begin
                w_latch      = 1'b1;
                w_state_next = PH1;
            end
        end else if (!stall) begin
            if (!w_fn_legal) begin
                w_done_next    = 1'b1;
                w_illegal_next = 1'b1;
                w_state_next   = IDLE;
            end else begin
                w_result_next = w_fn_result;
                w_phase_next  = r_state;
                w_valid_next  = 1'b1;
                w_done_next   = w_fn_last;
                if (w_fn_last) begin
                    w_state_next = IDLE;
                end else if (r_state == PH1) begin
                    w_state_next = PH2;
                end else begin
                    w_state_next = PH3;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_phase   <= 2'd0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_result  <= w_result_next;
            r_phase   <= w_phase_next;
            r_valid   <= w_valid_next;
            r_done    <= w_done_next;
            r_illegal <= w_illegal_next;
        end
    end

    // Capture the instruction word and call displacement on acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_opcode  <= 8'd0;
            r_operand <= 24'd0;
            r_imm     <= '0;
        end else if (w_latch) begin
            r_opcode  <= ope[31:24];
            r_operand <= ope[23:0];
            r_imm     <= immidiate_data;
        end
    end

    assign busy           = (r_state != IDLE);
    assign alu_result_bus = r_result;
    assign phase          = r_phase;
    assign result_valid   = r_valid;
    assign done           = r_done;
    assign illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (DATA_W=32,
//               STACK_STEP=1). Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] ope;
    logic [31:0] immidiate_data;
    logic [31:0] registor_in;
    logic        stall;
    logic        busy;
    logic [31:0] alu_result_bus;
    logic        result_valid;
    logic [1:0]  phase;
    logic        done;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(
        .DATA_W     (32),
        .STACK_STEP (1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .ope            (ope),
        .immidiate_data (immidiate_data),
        .registor_in    (registor_in),
        .stall          (stall),
        .busy           (busy),
        .alu_result_bus (alu_result_bus),
        .result_valid   (result_valid),
        .phase          (phase),
        .done           (done),
        .illegal        (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rv, input logic dn,
                             input logic il, input logic [1:0] ph, input logic [31:0] res);
        check({tag, ".valid"},   64'(result_valid),   64'(rv));
        check({tag, ".done"},    64'(done),           64'(dn));
        check({tag, ".illegal"}, 64'(illegal),        64'(il));
        check({tag, ".phase"},   64'(phase),          64'(ph));
        check({tag, ".result"},  64'(alu_result_bus), 64'(res));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present an instruction and let the next edge accept it.
    task automatic issue(input logic [31:0] op, input logic [31:0] imm);
        start          = 1'b1;
        ope            = op;
        immidiate_data = imm;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b1;
        start          = 1'b0;
        ope            = 32'h0;
        immidiate_data = 32'h0;
        registor_in    = 32'h0;
        stall          = 1'b0;
        #2 reset_n = 1'b0;
        tick();
        tick();
        check("reset.busy", 64'(busy), 64'd0);
        check_out("reset", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

        // Push, accepted on the first edge after release
        reset_n     = 1'b1;
        registor_in = 32'h100;
        issue(32'h5500_0000, 32'h0);
        check("push.accept.busy", 64'(busy), 64'd1);
        check("push.accept.valid", 64'(result_valid), 64'd0);
        start = 1'b1;                 // must be ignored while busy
        ope   = 32'h8900_0000;
        tick();
        start = 1'b0;
        check_out("push.ph1", 1'b1, 1'b0, 1'b0, 2'd1, 32'h101);
        tick();
        check_out("push.ph2", 1'b1, 1'b1, 1'b0, 2'd2, 32'h100);
        tick();
        check("push.idle.busy", 64'(busy), 64'd0);
        check_out("push.hold", 1'b0, 1'b0, 1'b0, 2'd2, 32'h100);

        // Mov, single phase
        registor_in = 32'h1234;
        issue(32'h8900_0000, 32'h0);
        tick();
        check_out("mov.ph1", 1'b1, 1'b1, 1'b0, 2'd1, 32'h1234);

        // Mov immediate, started on the IDLE cycle right after done
        issue(32'hb812_3456, 32'h0);
        tick();
        check_out("movi.ph1", 1'b1, 1'b0, 1'b0, 2'd1, 32'h0056_3412);
        tick();
        check_out("movi.ph2", 1'b1, 1'b1, 1'b0, 2'd2, 32'h3);

        // Pop
        registor_in = 32'h200;
        issue(32'h5d00_0000, 32'h0);
        tick();
        check_out("pop.ph1", 1'b1, 1'b0, 1'b0, 2'd1, 32'h200);
        tick();
        check_out("pop.ph2", 1'b1, 1'b1, 1'b0, 2'd2, 32'h1ff);

        // Ret from zero with a two-cycle stall in PH1
        registor_in = 32'h0;
        issue(32'hc300_0000, 32'h0);
        stall = 1'b1;
        tick();
        check_out("ret.stall1", 1'b0, 1'b0, 1'b0, 2'd2, 32'h1ff);
        tick();
        check_out("ret.stall2", 1'b0, 1'b0, 1'b0, 2'd2, 32'h1ff);
        check("ret.stall.busy", 64'(busy), 64'd1);
        stall = 1'b0;
        tick();
        check_out("ret.ph1", 1'b1, 1'b0, 1'b0, 2'd1, 32'hffff_ffff);
        tick();
        check_out("ret.ph2", 1'b1, 1'b1, 1'b0, 2'd2, 32'hffff_ffff);

        // Call
        registor_in = 32'h40;
        issue(32'he800_0000, 32'h10);
        immidiate_data = 32'h0;       // displacement must come from the latch
        tick();
        check_out("call.ph1", 1'b1, 1'b0, 1'b0, 2'd1, 32'h41);
        tick();
        check_out("call.ph2", 1'b1, 1'b0, 1'b0, 2'd2, 32'h40);
        tick();
`ifdef ALU_SEQ_CALL_REL_EN
        check_out("call.ph3", 1'b1, 1'b1, 1'b0, 2'd3, 32'h50);
`else
        check_out("call.ph3", 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
`endif

        // Unsupported opcode
        tick();
        issue(32'h0000_0000, 32'h0);
        tick();
`ifdef ALU_SEQ_CALL_REL_EN
        check_out("illegal", 1'b0, 1'b1, 1'b1, 2'd3, 32'h50);
`else
        check_out("illegal", 1'b0, 1'b1, 1'b1, 2'd3, 32'h0);
`endif
        tick();
        check("illegal.after", 64'(illegal), 64'd0);
        check("illegal.busy", 64'(busy), 64'd0);

        // Reset asserted during call PH2
        registor_in = 32'h40;
        issue(32'he800_0000, 32'h10);
        tick();
        check_out("rcall.ph1", 1'b1, 1'b0, 1'b0, 2'd1, 32'h41);
        reset_n = 1'b0;
        #1;
        check("rcall.busy", 64'(busy), 64'd0);
        check_out("rcall.reset", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rcall.release.done", 64'(done), 64'd0);
            check("rcall.release.valid", 64'(result_valid), 64'd0);
        end
        check("rcall.release.busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal range 24..64.
REQ-002 SHALL have parameter STACK_STEP, default 1, stack-pointer increment per push/pop/call/ret.
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to execute the instruction on ope.
REQ-006 SHALL have port ope  input  32  instruction word; opcode = ope[31:24], operand bytes ope[23:0].
REQ-007 SHALL have port immidiate_data  input  DATA_W  call displacement.
REQ-008 SHALL have port registor_in  input  DATA_W  register-file read value for the current phase.
REQ-009 SHALL have port stall  input  1  freezes the sequencer in its current phase.
REQ-010 SHALL have port busy  output  1  high while not IDLE.
REQ-011 SHALL have port alu_result_bus  output  DATA_W  registered phase result.
REQ-012 SHALL have port result_valid  output  1  one-cycle pulse per new alu_result_bus value.
REQ-013 SHALL have port phase  output  2  phase number (1..3) of the current result.
REQ-014 SHALL have port done  output  1  one-cycle pulse with the last result of an instruction.
REQ-015 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-016 SHALL implement FSM states IDLE, PH1, PH2, PH3.
REQ-017 In IDLE with start=1, SHALL latch ope and immidiate_data and enter PH1; start while busy SHALL be ignored.
REQ-018 In PHk with stall=0, SHALL register f_k(registor_in) to alu_result_bus, pulse result_valid, set phase=k.
REQ-019 With stall=1, SHALL hold state and all outputs; result_valid/done SHALL be 0.
REQ-020 Opcode 0x55 (push): PH1 registor_in+STACK_STEP, PH2 registor_in; 2 phases.
REQ-021 Opcode 0x89 (mov): PH1 registor_in; 1 phase.
REQ-022 Opcode 0xb8 (mov imm): PH1 zero-extended {ope[7:0],ope[15:8],ope[23:16]}, PH2 constant 3; 2 phases.
REQ-023 Opcode 0x5d (pop): PH1 registor_in, PH2 registor_in-STACK_STEP; 2 phases.
REQ-024 Opcode 0xc3 (ret): PH1 and PH2 registor_in-STACK_STEP; 2 phases.
REQ-025 Opcode 0xe8 (call): PH1 registor_in+STACK_STEP, PH2 registor_in, PH3 per REQ-034; 3 phases.
REQ-026 Last phase SHALL pulse done with result_valid and return to IDLE; next start accepted that same cycle after return (one IDLE cycle minimum).
REQ-027 Unsupported opcode SHALL pulse illegal and done in the cycle after acceptance, no result_valid, alu_result_bus unchanged, return to IDLE.
REQ-028 All arithmetic SHALL wrap modulo 2^DATA_W (0-STEP wraps to all-ones minus STEP-1).
REQ-029 Latency: start accepted at edge N, first result at edge N+1, one result per unstalled cycle.
REQ-030 alu_result_bus SHALL hold its last value between instructions.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, alu_result_bus=0, phase=0, busy, result_valid, done, illegal=0.
REQ-032 Reset mid-instruction SHALL abandon it; no done pulse after release.
REQ-033 First start SHALL be accepted on the first rising edge with reset_n high.

Configuration
REQ-034 Macro ALU_SEQ_CALL_REL_EN defined: call PH3 = registor_in + latched immidiate_data; undefined: call PH3 = 0.

Structure
REQ-035 Package alu_seq_pkg SHALL hold opcode constants (OP_PUSH 0x55, OP_MOV 0x89, OP_MOVI 0xb8, OP_POP 0x5d, OP_RET 0xc3, OP_CALL 0xe8) and the state enum.
REQ-036 Combinational phase function SHALL be sub-module alu_seq_fn (opcode, phase, operands -> result, last-phase flag).

Verification
REQ-037 Push: ope=0x55000000, registor_in=0x100 -> 0x101 phase1, 0x100 phase2 with done.
REQ-038 Mov imm: ope=0xb8123456 -> 0x00563412 phase1, 0x3 phase2 with done.
REQ-039 Call, macro on: registor_in=0x40, immidiate_data=0x10 -> 0x41, 0x40, 0x50 with done; macro off -> third result 0.
REQ-040 Wrap/stall: ret with registor_in=0, stall high 2 cycles in PH1 -> no pulses while stalled, then 0xFFFFFFFF twice.
REQ-041 ope=0x00000000 -> illegal and done pulse, no result_valid; start during push PH1 ignored.
REQ-042 reset_n low during call PH2 -> outputs zero immediately, no done after release.
